// File: rtl/HermesPkg.sv
// Purpose : shared types and helpers for the Hermes local-port arbiter.
// Latency : n/a (types and pure functions only).
// Backpr. : n/a.
package HermesPkg;

  // One-hot packet-framing state of the local-port arbiter.
  typedef enum logic [3:0] {
    ARB_IDLE    = 4'b0001,
    ARB_HEADER  = 4'b0010,
    ARB_SIZE    = 4'b0100,
    ARB_PAYLOAD = 4'b1000
  } hermes_arb_state_t;

  // Round-robin search distance from the last grant to candidate 'to'.
  // The channel right after 'from' has distance 0, and 'from' itself has
  // distance n-1. The last winner therefore ranks lowest and wins only
  // when it is the sole requester.
  function automatic int rr_distance(input int from, input int to, input int n);
    return (to - from - 1 + n) % n;
  endfunction

endpackage

// File: rtl/hermes_rr_arbiter.sv
// Purpose : combinational round-robin pick among NCHAN requesters.
// Latency : 0 cycles (pure combinational).
// Backpr. : none; the caller decides when the winner is latched.
//
// Ports:
//   req    : request vector, one bit per channel
//   last   : previously granted channel; the search starts at last+1
//   winner : first requesting channel at or after last+1, modulo NCHAN
//   found  : at least one request is present (winner is valid)
module hermes_rr_arbiter
  import HermesPkg::*;
#(
  parameter int NCHAN = 4,
  parameter int GW    = $clog2(NCHAN)
) (
  input  logic [NCHAN-1:0] req,
  input  logic [GW-1:0]    last,
  output logic [GW-1:0]    winner,
  output logic             found
);

  int best;

  // Keep the requester with the smallest wrap-around distance from 'last'.
  // This is equivalent to scanning last+1, last+2, ... and stopping at the
  // first request, but it avoids a variable-indexed loop.
  always_comb begin
    winner = last;
    best   = NCHAN;
    for (int c = 0; c < NCHAN; c++) begin
      if (req[c] && (rr_distance(int'(last), c, NCHAN) < best)) begin
        best   = rr_distance(int'(last), c, NCHAN);
        winner = GW'(c);
      end
    end
  end

  assign found = |req;

endmodule

// File: rtl/hermes_local_arbiter.sv
// Purpose : shares one Hermes router local input port among NCHAN producers,
//           holding the grant for a whole packet (header, size, size payloads).
// Latency : data is pass-through (0 cycles). There is a 1-cycle arbitration
//           bubble in IDLE before each header.
// Backpr. : credit_i low stalls the granted channel (ready low). A granted
//           channel that drops valid stalls the port; others wait.
//
// Ports:
//   clk_i, rst_i : clock and asynchronous active-high reset
//   ch_valid_i   : per-channel flit valid
//   ch_data_i    : per-channel flits, channel i at [i*FLIT_SIZE +: FLIT_SIZE]
//   ch_ready_o   : flit of the granted channel is consumed when valid
//   tx_o, data_o : flit toward the router local port (data_o is 0 when idle)
//   credit_i     : router local buffer can take a flit this cycle
//   grant_o      : currently/last granted channel
//   busy_o       : a packet is in progress
//   pkt_done_o   : last flit of a packet transferred this cycle
module hermes_local_arbiter
  import HermesPkg::*;
#(
  parameter int NCHAN     = 4,
  parameter int FLIT_SIZE = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NCHAN-1:0]           ch_valid_i,
  input  logic [NCHAN*FLIT_SIZE-1:0] ch_data_i,
  output logic [NCHAN-1:0]           ch_ready_o,
  output logic                       tx_o,
  output logic [FLIT_SIZE-1:0]       data_o,
  input  logic                       credit_i,
  output logic [$clog2(NCHAN)-1:0]   grant_o,
  output logic                       busy_o,
  output logic                       pkt_done_o
);

  localparam int GW = $clog2(NCHAN);
  localparam logic [FLIT_SIZE-1:0] CNT_ONE = FLIT_SIZE'(1);

  hermes_arb_state_t    state, state_nxt;
  logic [GW-1:0]        grant, grant_nxt;
  logic [FLIT_SIZE-1:0] cnt, cnt_nxt;
  logic [FLIT_SIZE-1:0] data_sel;
  logic                 valid_sel;
  logic                 busy;
  logic                 xfer;
  logic                 pkt_done;
  logic [GW-1:0]        rr_winner;
  logic                 rr_found;

  hermes_rr_arbiter #(
    .NCHAN (NCHAN),
    .GW    (GW)
  ) u_rr (
    .req    (ch_valid_i),
    .last   (grant),
    .winner (rr_winner),
    .found  (rr_found)
  );

  // Select the granted channel's flit and valid.
  always_comb begin
    data_sel  = '0;
    valid_sel = 1'b0;
    for (int c = 0; c < NCHAN; c++) begin
      if (grant == GW'(c)) begin
        data_sel  = ch_data_i[c*FLIT_SIZE +: FLIT_SIZE];
        valid_sel = ch_valid_i[c];
      end
    end
  end

  assign busy = (state != ARB_IDLE);
  assign xfer = busy && valid_sel && credit_i;

  // Ready depends only on credit, not on the channel's own valid.
  // A producer that is not presenting a flit simply ignores it.
  always_comb begin
    ch_ready_o = '0;
    for (int c = 0; c < NCHAN; c++) begin
      if (busy && credit_i && (grant == GW'(c))) begin
        ch_ready_o[c] = 1'b1;
      end
    end
  end

  // State register. Reset is asynchronous, so a packet in flight is
  // dropped immediately. grant resets to the last channel so that the
  // first search lands on channel 0.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= ARB_IDLE;
      grant <= GW'(NCHAN - 1);
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic. Nothing moves without a transfer. The grant changes
  // only when leaving IDLE, so requests raised mid-packet wait for the
  // next arbitration.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    cnt_nxt   = cnt;
    pkt_done  = 1'b0;
    unique case (state)
      ARB_IDLE: begin
        if (rr_found) begin
          grant_nxt = rr_winner;
          state_nxt = ARB_HEADER;
        end
      end
      ARB_HEADER: begin
        if (xfer) begin
          state_nxt = ARB_SIZE;
        end
      end
      ARB_SIZE: begin
        if (xfer) begin
          cnt_nxt = data_sel;
          if (data_sel == '0) begin
            state_nxt = ARB_IDLE;
            pkt_done  = 1'b1;
          end else begin
            state_nxt = ARB_PAYLOAD;
          end
        end
      end
      ARB_PAYLOAD: begin
        if (xfer) begin
          cnt_nxt = cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            state_nxt = ARB_IDLE;
            pkt_done  = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = ARB_IDLE;
      end
    endcase
  end

  assign tx_o       = busy && valid_sel;
  assign data_o     = busy ? data_sel : '0;
  assign grant_o    = grant;
  assign busy_o     = busy;
  assign pkt_done_o = pkt_done;

endmodule

// File: tb/tb_hermes_local_arbiter.sv
// Purpose : self-checking bench for hermes_local_arbiter. A packet-level model
//           is compared against the DUT every cycle, and directed scenarios
//           pin the model with literal expectations.
// Latency : n/a.
// Backpr. : drives credit_i and per-channel stalls, both directed and random.
module tb_hermes_local_arbiter;

  localparam int NCH = 4;
  localparam int FW  = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [NCH-1:0]    ch_valid;
  logic [NCH*FW-1:0] ch_data;
  logic [NCH-1:0]    ch_ready;
  logic              tx;
  logic [FW-1:0]     data;
  logic              credit;
  logic [1:0]        grant;
  logic              busy;
  logic              done;

  always #5 clk = ~clk;

  hermes_local_arbiter #(.NCHAN(NCH), .FLIT_SIZE(FW)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .ch_valid_i (ch_valid),
    .ch_data_i  (ch_data),
    .ch_ready_o (ch_ready),
    .tx_o       (tx),
    .data_o     (data),
    .credit_i   (credit),
    .grant_o    (grant),
    .busy_o     (busy),
    .pkt_done_o (done)
  );

  // Producer side: one flit queue per channel, plus a stall mask.
  logic [FW-1:0] chq [NCH][$];
  logic [NCH-1:0] stall;

  // Packet-level model of the arbiter.
  bit     m_busy;
  int     m_grant;
  int     m_pos;      // 0 = header next, 1 = size next, 2 = payload
  longint m_rem;      // payload flits still owed

  // Observations of the DUT, used by the directed literal checks.
  int            log_cyc[$];
  int            log_ch[$];
  logic [FW-1:0] log_data[$];
  int            done_cyc[$];
  int            cyc;
  logic          last_tx, last_busy;
  logic [NCH-1:0] last_ready;
  logic [FW-1:0] last_data;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic clr_logs();
    log_cyc.delete(); log_ch.delete(); log_data.delete(); done_cyc.delete();
  endtask

  task automatic drive();
    for (int c = 0; c < NCH; c++) begin
      ch_valid[c] = (chq[c].size() > 0) && !stall[c];
      ch_data[c*FW +: FW] = (chq[c].size() > 0) ? chq[c][0] : FW'($urandom());
    end
  endtask

  function automatic bit all_empty();
    for (int c = 0; c < NCH; c++) if (chq[c].size() > 0) return 1'b0;
    return 1'b1;
  endfunction

  // One clock cycle: drive, compare against the model, then advance the
  // model and the producers on the clock edge.
  task automatic step();
    logic [FW-1:0]  ed;
    logic [NCH-1:0] erdy;
    logic           etx, exf, edone;
    drive();
    #1;
    ed    = m_busy ? ch_data[m_grant*FW +: FW] : '0;
    etx   = m_busy && ch_valid[m_grant];
    erdy  = (m_busy && credit) ? (4'b0001 << m_grant) : 4'b0000;
    exf   = etx && credit;
    edone = exf && ((m_pos == 1 && ed == 0) || (m_pos == 2 && m_rem == 1));
    chk("tx_o", tx, etx);
    chk("data_o", data, ed);
    chk("ch_ready_o", ch_ready, erdy);
    chk("busy_o", busy, m_busy);
    chk("grant_o", grant, m_grant);
    chk("pkt_done_o", done, edone);
    last_tx = tx; last_busy = busy; last_ready = ch_ready; last_data = data;
    if (tx && credit) begin
      log_cyc.push_back(cyc); log_ch.push_back(int'(grant)); log_data.push_back(data);
    end
    if (done) done_cyc.push_back(cyc);
    @(posedge clk);
    if (!m_busy) begin
      if (|ch_valid) begin
        for (int k = 1; k <= NCH; k++) begin
          int c;
          c = (m_grant + k) % NCH;
          if (ch_valid[c]) begin
            m_grant = c;
            break;
          end
        end
        m_busy = 1'b1;
        m_pos  = 0;
      end
    end else if (exf) begin
      void'(chq[m_grant].pop_front());
      if (m_pos == 0) m_pos = 1;
      else if (m_pos == 1) begin
        m_rem = longint'(ed);
        if (m_rem == 0) m_busy = 1'b0; else m_pos = 2;
      end else begin
        m_rem--;
        if (m_rem == 0) m_busy = 1'b0;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  // Reset asserted mid-cycle (between edges). The outputs must clear at
  // once, before any clock edge arrives.
  task automatic async_reset(input string name);
    #2 rst = 1'b1;
    #1;
    chk({name, "_tx"}, tx, 1'b0);
    chk({name, "_ready"}, ch_ready, 4'b0000);
    chk({name, "_busy"}, busy, 1'b0);
    chk({name, "_done"}, done, 1'b0);
    chk({name, "_data"}, data, 32'h0);
    chk({name, "_grant"}, grant, 2'd3);
    m_busy = 1'b0; m_grant = NCH - 1; m_pos = 0; m_rem = 0;
    for (int c = 0; c < NCH; c++) chq[c].delete();
    stall = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_until_idle(input int maxc, input string name);
    int n;
    n = 0;
    while ((!all_empty() || m_busy) && n < maxc) begin
      step();
      n++;
    end
    chk({name, "_bound"}, (n < maxc), 1'b1);
  endtask

  initial begin
    logic [FW-1:0] exp1[5];
    int c0;
    rst = 1'b1; credit = 1'b0; stall = '0; ch_valid = '0; ch_data = '0; cyc = 0;
    m_busy = 1'b0; m_grant = NCH - 1; m_pos = 0; m_rem = 0;
    @(negedge clk);
    async_reset("reset");

    // Single packet on ch0: header, size 3, three payload flits.
    credit = 1'b1;
    clr_logs();
    exp1[0] = 32'h0000_0102; exp1[1] = 32'd3;
    exp1[2] = 32'hAAAA_0001; exp1[3] = 32'hBBBB_0002; exp1[4] = 32'hCCCC_0003;
    for (int i = 0; i < 5; i++) chq[0].push_back(exp1[i]);
    c0 = cyc;
    repeat (7) step();
    chk("t1_nflits", log_data.size(), 5);
    if (log_data.size() == 5) begin
      chk("t1_first_cyc", log_cyc[0], c0 + 1);
      chk("t1_last_cyc", log_cyc[4], c0 + 5);
      for (int i = 0; i < 5; i++) chk("t1_data", log_data[i], exp1[i]);
    end
    chk("t1_ndone", done_cyc.size(), 1);
    if (done_cyc.size() == 1) chk("t1_done_cyc", done_cyc[0], c0 + 5);
    chk("t1_busy_after", last_busy, 1'b0);

    // Round robin: ch0 (two packets), ch1 and ch3, each packet of size 0.
    async_reset("t2_rst");
    credit = 1'b1;
    clr_logs();
    chq[0].push_back(32'h0000_0A00); chq[0].push_back(0);
    chq[0].push_back(32'h0000_0A01); chq[0].push_back(0);
    chq[1].push_back(32'h0000_0B00); chq[1].push_back(0);
    chq[3].push_back(32'h0000_0D00); chq[3].push_back(0);
    run_until_idle(60, "t2");
    chk("t2_nflits", log_ch.size(), 8);
    if (log_ch.size() == 8) begin
      chk("t2_grant0", log_ch[0], 0);
      chk("t2_grant1", log_ch[2], 1);
      chk("t2_grant2", log_ch[4], 3);
      chk("t2_grant3", log_ch[6], 0);
      for (int p = 0; p < 4; p++) chk("t2_nointerleave", log_ch[2*p+1], log_ch[2*p]);
      for (int p = 1; p < 4; p++) chk("t2_gap", log_cyc[2*p] - log_cyc[2*p-1], 2);
      chk("t2_hdr3", log_data[6], 32'h0000_0A01);
    end

    // Backpressure on a size-2 payload.
    clr_logs();
    chq[0].push_back(32'h0000_0C00); chq[0].push_back(2);
    chq[0].push_back(32'h1111_0000); chq[0].push_back(32'h2222_0000);
    repeat (3) step();
    credit = 1'b0;
    repeat (3) begin
      step();
      chk("t3_tx_held", last_tx, 1'b1);
      chk("t3_ready_low", last_ready, 4'b0000);
      chk("t3_data_stable", last_data, 32'h1111_0000);
    end
    credit = 1'b1;
    run_until_idle(20, "t3");
    chk("t3_nflits", log_data.size(), 4);
    if (log_data.size() == 4) begin
      chk("t3_p0", log_data[2], 32'h1111_0000);
      chk("t3_p1", log_data[3], 32'h2222_0000);
      if (done_cyc.size() > 0) chk("t3_done", done_cyc[0], log_cyc[3]);
    end

    // Channel stall: granted ch2 drops valid while ch1 is waiting.
    clr_logs();
    chq[2].push_back(32'h0000_2200); chq[2].push_back(3);
    chq[2].push_back(32'h2000_0001); chq[2].push_back(32'h2000_0002); chq[2].push_back(32'h2000_0003);
    step();
    chq[1].push_back(32'h0000_1100); chq[1].push_back(0);
    repeat (3) step();
    stall[2] = 1'b1;
    repeat (2) begin
      step();
      chk("t4_tx_low", last_tx, 1'b0);
      chk("t4_ready1_low", last_ready[1], 1'b0);
    end
    stall[2] = 1'b0;
    run_until_idle(40, "t4");
    chk("t4_nflits", log_ch.size(), 7);
    if (log_ch.size() == 7) begin
      chk("t4_ch2_last", log_ch[4], 2);
      chk("t4_ch1_after", log_ch[5], 1);
      chk("t4_ch1_hdr", log_data[5], 32'h0000_1100);
    end

    // Huge size flit, reset in the middle of the payload.
    clr_logs();
    chq[0].push_back(32'h0000_5500); chq[0].push_back(32'hFFFF_FFFF);
    for (int i = 0; i < 8; i++) chq[0].push_back(32'h5000_0000 + i);
    repeat (8) step();
    chk("t5_nflits", log_data.size(), 7);
    async_reset("t5_rst");
    clr_logs();
    chq[1].push_back(32'h0000_5B00); chq[1].push_back(0);
    chq[0].push_back(32'h0000_5A00); chq[0].push_back(0);
    run_until_idle(30, "t5");
    chk("t5_nflits2", log_ch.size(), 4);
    if (log_ch.size() == 4) begin
      chk("t5_first_ch0", log_ch[0], 0);
      chk("t5_then_ch1", log_ch[2], 1);
    end

    // Size zero with immediate re-request from the only requester.
    clr_logs();
    chq[0].push_back(32'h0000_6600); chq[0].push_back(0);
    chq[0].push_back(32'h0000_6601); chq[0].push_back(0);
    run_until_idle(20, "t6");
    chk("t6_nflits", log_ch.size(), 4);
    chk("t6_ndone", done_cyc.size(), 2);
    if (log_ch.size() == 4 && done_cyc.size() == 2) begin
      chk("t6_done_on_size", done_cyc[0], log_cyc[1]);
      chk("t6_gap", log_cyc[2] - log_cyc[1], 2);
      chk("t6_regrant", log_ch[2], 0);
    end

    // Randomized traffic, credit and stalls.
    for (int t = 0; t < 1500; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        int c, sz;
        c  = $urandom_range(0, NCH - 1);
        sz = $urandom_range(0, 4);
        if (chq[c].size() < 12) begin
          chq[c].push_back($urandom());
          chq[c].push_back(FW'(sz));
          for (int i = 0; i < sz; i++) chq[c].push_back($urandom());
        end
      end
      credit = ($urandom_range(0, 9) < 7);
      for (int c = 0; c < NCH; c++) stall[c] = ($urandom_range(0, 9) == 0);
      step();
    end
    stall = '0;
    credit = 1'b1;
    run_until_idle(600, "rand_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
